// File: rtl/memory_fpga_ctrl_pkg.sv
// Shared types and defaults for the switch/button memory front-end.
// Imported by memory_fpga_ctrl and btn_edge_sync.
package memory_fpga_ctrl_pkg;

  localparam int DEFAULT_DATA_W      = 16;
  localparam int DEFAULT_ADDR_W      = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/memory_fpga_ctrl_btn_edge_sync.sv
// Raw push-button synchroniser followed by a rising-edge detector.
// It emits a single-cycle pulse per press, however long the button is held.
module btn_edge_sync
  import memory_fpga_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic initialise,
  input  logic btn_raw,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (initialise) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/memory_fpga_ctrl.sv
// Board memory front-end: switches give address/data, buttons latch address and commit writes.
// Optional macro MEMORY_FPGA_AUTO_INC_EN advances the address after every committed write.
module memory_fpga_ctrl
  import memory_fpga_ctrl_pkg::*;
#(
  parameter int                DATA_W      = DEFAULT_DATA_W,
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL    = '0,
  parameter int                SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              initialise,
  input  logic [DATA_W-1:0] SW,
  input  logic              BTN_addr,
  input  logic              BTN_write,
  output logic [DATA_W-1:0] out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_next;
  logic [ADDR_W-1:0] addr_next;
  logic              busy_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              addr_pulse;
  logic              write_pulse;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_addr (
    .clk        (clk),
    .initialise (initialise),
    .btn_raw    (BTN_addr),
    .pulse      (addr_pulse)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_write (
    .clk        (clk),
    .initialise (initialise),
    .btn_raw    (BTN_write),
    .pulse      (write_pulse)
  );

  always_ff @(posedge clk) begin
    if (initialise) begin
      state    <= ST_CLEAR;
      clr_ptr  <= '0;
      addr_out <= '0;
      busy     <= 1'b1;
    end else begin
      state    <= state_next;
      clr_ptr  <= clr_ptr_next;
      addr_out <= addr_next;
      busy     <= busy_next;
    end
  end

  // Button pulses are only honoured in IDLE; during CLEAR they fall on the floor.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    addr_next    = addr_out;
    busy_next    = busy;
    mem_we       = 1'b0;
    mem_waddr    = addr_out;
    mem_wdata    = SW;
    case (state)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_ptr;
        mem_wdata    = INIT_VAL;
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end
      end
      ST_IDLE: begin
        busy_next = 1'b0;
        if (write_pulse) begin
          mem_we = 1'b1;
`ifdef MEMORY_FPGA_AUTO_INC_EN
          addr_next = addr_out + 1'b1;
`else
          addr_next = addr_out;
`endif
        end
        // A same-cycle address press overrides any auto-increment; the write still used the old address.
        if (addr_pulse) begin
          addr_next = SW[ADDR_W-1:0];
        end
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we && !initialise) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read-before-write: a write or address change appears on out one edge later.
  always_ff @(posedge clk) begin
    if (initialise) begin
      out <= '0;
    end else if (state == ST_IDLE) begin
      out <= mem[addr_out];
    end
  end

endmodule

// File: tb/tb_memory_fpga_ctrl.sv
// Directed self-checking bench for memory_fpga_ctrl at DATA_W=16, ADDR_W=4, SYNC_STAGES=2.
module tb_memory_fpga_ctrl;

`ifdef MEMORY_FPGA_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        initialise;
  logic [15:0] SW;
  logic        BTN_addr;
  logic        BTN_write;
  logic [15:0] out;
  logic [3:0]  addr_out;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  memory_fpga_ctrl #(
    .DATA_W      (16),
    .ADDR_W      (4),
    .INIT_VAL    (16'h0000),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .initialise (initialise),
    .SW         (SW),
    .BTN_addr   (BTN_addr),
    .BTN_write  (BTN_write),
    .out        (out),
    .addr_out   (addr_out),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives buttons high for one cycle; returns at the negedge after the first sampling edge.
  task automatic applyStimulus(input logic [15:0] sw, input logic ba, input logic bw);
    @(negedge clk);
    SW        = sw;
    BTN_addr  = ba;
    BTN_write = bw;
    @(negedge clk);
    BTN_addr  = 1'b0;
    BTN_write = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    initialise = 1'b1;
    @(negedge clk);
    initialise = 1'b0;
  endtask

  task automatic readWord(input logic [3:0] a, input logic [15:0] exp, input string tag);
    applyStimulus({12'h000, a}, 1'b1, 1'b0);
    waitCycles(3);
    checkOutput(tag, {16'h0, out}, {16'h0, exp});
  endtask

  // Counts busy cycles from the negedge after the reset edge, bounded at 40.
  task automatic measureBusy(input bit inject, output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cnt++;
      if (inject && i == 1) begin
        SW        = 16'hBEE5;
        BTN_addr  = 1'b1;
        BTN_write = 1'b1;
      end
      if (inject && i == 2) begin
        BTN_addr  = 1'b0;
        BTN_write = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    initialise = 1'b1;
    SW         = 16'h0000;
    BTN_addr   = 1'b0;
    BTN_write  = 1'b0;

    // 1: reset, clear duration, all words at INIT_VAL
    doReset();
    checkOutput("reset_out", {16'h0, out}, 32'h0);
    checkOutput("reset_addr", {28'h0, addr_out}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h1);
    measureBusy(1'b0, busy_cnt);
    checkOutput("busy_len", busy_cnt, 32'd16);
    for (int a = 0; a < 16; a++) begin
      readWord(4'(a), 16'h0000, $sformatf("clear_rd%0d", a));
    end

    // 2: latch address 1, write 0xF0F0, check latency on out
    applyStimulus(16'h0001, 1'b1, 1'b0);
    waitCycles(3);
    checkOutput("addr_latch", {28'h0, addr_out}, 32'h1);
    applyStimulus(16'hF0F0, 1'b0, 1'b1);
    waitCycles(2);
    checkOutput("wr_out_edge2", {16'h0, out}, 32'h0);
    checkOutput("wr_addr_after", {28'h0, addr_out}, AUTO_INC ? 32'h2 : 32'h1);
    waitCycles(1);
    checkOutput("wr_out_edge3", {16'h0, out}, AUTO_INC ? 32'h0 : 32'hF0F0);
    readWord(4'd1, 16'hF0F0, "rd_addr1");

    // 3: held write button with changing SW commits once, with SW at commit edge
    readWord(4'd3, 16'h0000, "rd_addr3_pre");
    @(negedge clk);
    SW        = 16'h1000;
    BTN_write = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      SW = 16'h1000 + 16'(i + 1);
    end
    BTN_write = 1'b0;
    waitCycles(3);
    checkOutput("hold_addr", {28'h0, addr_out}, AUTO_INC ? 32'h4 : 32'h3);
    readWord(4'd3, 16'h1002, "hold_rd3");
    readWord(4'd4, 16'h0000, "hold_rd4");

    // 4: simultaneous press writes old address, then latches new one
    readWord(4'd2, 16'h0000, "rd_addr2_pre");
    applyStimulus(16'h0005, 1'b1, 1'b1);
    waitCycles(2);
    checkOutput("both_addr", {28'h0, addr_out}, 32'h5);
    readWord(4'd2, 16'h0005, "both_rd2");
    readWord(4'd5, 16'h0000, "both_rd5");

    // 5: write at top address, auto-increment wraps
    readWord(4'd15, 16'h0000, "rd_addr15_pre");
    applyStimulus(16'hAAAA, 1'b0, 1'b1);
    waitCycles(2);
    checkOutput("wrap_addr", {28'h0, addr_out}, AUTO_INC ? 32'h0 : 32'hF);
    readWord(4'd15, 16'hAAAA, "wrap_rd15");

    // 6: re-initialise mid-clear with presses during busy
    doReset();
    waitCycles(7);
    checkOutput("midclear_busy", {31'h0, busy}, 32'h1);
    doReset();
    measureBusy(1'b1, busy_cnt);
    checkOutput("restart_busy_len", busy_cnt, 32'd16);
    checkOutput("restart_addr", {28'h0, addr_out}, 32'h0);
    for (int a = 0; a < 16; a++) begin
      readWord(4'(a), 16'h0000, $sformatf("restart_rd%0d", a));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
